// File: rtl/rca_pkg.sv
// Shared types and elaboration helpers for the pipelined ripple-carry adder.
// The per-stage flag bundle is width-independent; operand vectors live in the stage itself.
package rca_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
        logic cmsb;
    } stage_flags_t;

    function automatic bit geometry_ok(input int width, input int stages);
        return (width > 0) && (stages > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_pipe_stage.sv
// One skewed pipeline stage: adds its CHUNK-bit slice, forwards the unconsumed operand
// bits and the sum bits produced so far, and holds its beat while downstream stalls.
module rca_pipe_stage
    import rca_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             carry_in,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             cmsb_out
);

    localparam int LO  = IDX * CHUNK;
    localparam int MSB = LO + CHUNK - 1;
    // Operand bits at or below this stage's slice are consumed; clearing them lets
    // synthesis drop those register bits.
    localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << (LO + CHUNK);

    stage_flags_t     flags_q;
    logic [CHUNK:0]   chunk_add;
    logic [WIDTH-1:0] sum_next;
    logic             cmsb_next;

    always_comb begin
        chunk_add = {1'b0, a_in[LO +: CHUNK]} + {1'b0, b_in[LO +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_in};
        sum_next = sum_in;
        sum_next[LO +: CHUNK] = chunk_add[CHUNK-1:0];
        cmsb_next = a_in[MSB] ^ b_in[MSB] ^ chunk_add[CHUNK-1];
    end

    assign ready = ~flags_q.valid | down_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            a_out   <= '0;
            b_out   <= '0;
            sum_out <= '0;
        end else if (ready) begin
            flags_q.valid <= up_valid;
            if (up_valid) begin
                flags_q.carry <= chunk_add[CHUNK];
                flags_q.cmsb  <= cmsb_next;
                a_out         <= a_in & HI_MASK;
                b_out         <= b_in & HI_MASK;
                sum_out       <= sum_next;
            end
        end
    end

    assign valid     = flags_q.valid;
    assign carry_out = flags_q.carry;
    assign cmsb_out  = flags_q.cmsb;

endmodule

// File: rtl/rca_pipe_add.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// The carry chain is cut into STAGES equal chunks, one chunk per pipeline stage.
module rca_pipe_add
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("rca_pipe_add: WIDTH must be a positive multiple of STAGES");
    end

    logic [STAGES:0] valid_p;
    logic [STAGES:0] ready_p;
    logic [STAGES:0] carry_p;
    logic [WIDTH-1:0] a_p   [STAGES+1];
    logic [WIDTH-1:0] b_p   [STAGES+1];
    logic [WIDTH-1:0] sum_p [STAGES+1];
    logic             cmsb_p [STAGES];

    // Subtraction is a + ~b + ~cin; inverting here latches the mode with the beat.
    assign valid_p[0]      = in_valid;
    assign a_p[0]          = a;
    assign b_p[0]          = sub ? ~b : b;
    assign sum_p[0]        = '0;
    assign carry_p[0]      = sub ? ~cin : cin;
    assign ready_p[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_pipe_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (valid_p[k]),
            .a_in       (a_p[k]),
            .b_in       (b_p[k]),
            .sum_in     (sum_p[k]),
            .carry_in   (carry_p[k]),
            .down_ready (ready_p[k+1]),
            .ready      (ready_p[k]),
            .valid      (valid_p[k+1]),
            .a_out      (a_p[k+1]),
            .b_out      (b_p[k+1]),
            .sum_out    (sum_p[k+1]),
            .carry_out  (carry_p[k+1]),
            .cmsb_out   (cmsb_p[k])
        );
    end

    assign in_ready  = ready_p[0] & ~rst;
    assign out_valid = valid_p[STAGES];
    assign sum       = sum_p[STAGES];
    assign cout      = carry_p[STAGES];
    assign ovf       = cmsb_p[STAGES-1] ^ carry_p[STAGES];

endmodule
